// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the even/odd byte-bank memory arbiter.
//   req_id_t     requester id (0 = CPU, 1 = DMA/debug master)
//   BANK_*       bank select values taken from byte address bit 0
//   DEFAULT_LAST round-robin pointer reset value; the CPU wins first contention
//   bank_req_t   one requester's access as seen by a single bank
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef logic req_id_t;

  localparam logic    BANK_EVEN    = 1'b0;
  localparam logic    BANK_ODD     = 1'b1;
  localparam req_id_t DEFAULT_LAST = 1'b1;

  // Upper bound for the bank word address carried in bank_req_t; instances use
  // only the low ADDRBITS-1 bits.
  localparam int WADDR_MAX = 31;

  typedef struct packed {
    logic                 valid;  // request targets this bank
    logic                 we;     // 1 = write, 0 = read
    logic [WADDR_MAX-1:0] waddr;  // bank word address (read or write)
    logic [7:0]           wdata;
  } bank_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Requester and memory-bank signals of the arbiter.
//   slave  : arbiter side (requests and bank read data in; grants, read
//            return and bank address/data/strobes out)
//   master : requesters plus memory (the opposite directions)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDRBITS = 16
);
  // requester side
  logic                req0, req1;
  logic                we0, we1;
  logic [ADDRBITS-1:0] addr0, addr1;
  logic [7:0]          wdata0, wdata1;
  logic                lock0, lock1;
  logic                gnt0, gnt1;
  logic                rvalid0, rvalid1;
  logic [7:0]          rdata0, rdata1;

  // memory bank side
  logic [ADDRBITS-2:0] read_addr_even, read_addr_odd;
  logic [ADDRBITS-2:0] write_addr_even, write_addr_odd;
  logic                write_en_even, write_en_odd;
  logic [7:0]          write_data_even, write_data_odd;
  logic [7:0]          read_data_even, read_data_odd;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  read_data_even, read_data_odd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output read_addr_even, read_addr_odd, write_addr_even, write_addr_odd,
    output write_en_even, write_en_odd, write_data_even, write_data_odd
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output read_data_even, read_data_odd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  read_addr_even, read_addr_odd, write_addr_even, write_addr_odd,
    input  write_en_even, write_en_odd, write_data_even, write_data_odd
  );
endinterface

// File: rtl/mem_arb_bank.sv
// ---------------------------------------------------------------------------
// mem_arb_bank
// Arbitration for a single byte bank: round-robin between the two requesters
// with an optional ownership lock (macro MEM_ARB_LOCK_EN).
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req0_i, req1_i           per-bank requests (valid only if targeting here)
//   lock0_i, lock1_i         hold ownership after this access (lock builds)
//   own_req0_i, own_req1_i   raw requester req lines, for lock release
//   gnt_o[1:0]               grant vector, bit i = requester i
//   read_addr_o              bank read word address
//   write_addr_o/data_o/en_o bank write port
// ---------------------------------------------------------------------------
module mem_arb_bank
  import mem_arb_pkg::*;
#(
  parameter int ADDRBITS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  bank_req_t           req0_i,
  input  bank_req_t           req1_i,
  input  logic                lock0_i,
  input  logic                lock1_i,
  input  logic                own_req0_i,
  input  logic                own_req1_i,
  output logic [1:0]          gnt_o,
  output logic [ADDRBITS-2:0] read_addr_o,
  output logic [ADDRBITS-2:0] write_addr_o,
  output logic                write_en_o,
  output logic [7:0]          write_data_o
);

  logic [1:0] vld;
  req_id_t    last_q, last_d;
  req_id_t    win_id;
  logic       granted;
  bank_req_t  win;

  assign vld = {req1_i.valid, req0_i.valid};

`ifdef MEM_ARB_LOCK_EN
  logic    owner_vld_q, owner_vld_d;
  req_id_t owner_id_q, owner_id_d;
`endif

  // Grant selection: a lone requester wins; on contention the requester that
  // was not granted last time wins. A valid owner excludes the other side even
  // when the owner itself is idle.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    gnt_o = vld;
    if (vld == 2'b11) begin
      gnt_o          = '0;
      gnt_o[~last_q] = 1'b1;
    end
`ifdef MEM_ARB_LOCK_EN
    if (owner_vld_q) begin
      gnt_o             = '0;
      gnt_o[owner_id_q] = vld[owner_id_q];
    end
`endif
  end

  assign granted = |gnt_o;
  assign win_id  = gnt_o[1];
  assign win     = win_id ? req1_i : req0_i;

  // Bank port: an idle bank drives all zeros; a read leaves the write side
  // quiet and a write leaves read_addr at zero.
  always_comb begin
    read_addr_o  = '0;
    write_addr_o = '0;
    write_en_o   = 1'b0;
    write_data_o = '0;
    if (granted) begin
      if (win.we) begin
        write_en_o   = 1'b1;
        write_addr_o = win.waddr[ADDRBITS-2:0];
        write_data_o = win.wdata;
      end else begin
        read_addr_o  = win.waddr[ADDRBITS-2:0];
      end
    end
  end

  assign last_d = granted ? win_id : last_q;

`ifdef MEM_ARB_LOCK_EN
  logic own_req, win_lock;
  assign own_req  = owner_id_q ? own_req1_i : own_req0_i;
  assign win_lock = win_id ? lock1_i : lock0_i;

  // Ownership drops as soon as the owner stops requesting; otherwise each
  // grant re-evaluates it from the winner's lock bit.
  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_id_d  = owner_id_q;
    if (owner_vld_q && !own_req) begin
      owner_vld_d = 1'b0;
    end else if (granted) begin
      owner_vld_d = win_lock;
      owner_id_d  = win_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_vld_q <= 1'b0;
      owner_id_q  <= '0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_id_q  <= owner_id_d;
    end
  end
`else
  // Lock inputs exist on every build but only matter when locking is enabled.
  logic unused_lock;
  assign unused_lock = ^{lock0_i, lock1_i, own_req0_i, own_req1_i};
`endif

  // Only ADDRBITS-1 word address bits are meaningful for this instance.
  logic unused_addr;
  assign unused_addr = ^{req0_i.waddr, req1_i.waddr};

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // its inputs from before the edge, independent of process ordering.
    if (!reset_n) last_q <= DEFAULT_LAST;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares an even/odd byte-bank memory between requester 0 (CPU) and
// requester 1 (DMA/debug). Accesses to different banks proceed in the same
// cycle; contention on a bank is resolved round-robin per bank. Read data
// returns one cycle after the grant to the requester that issued the read.
// Optional bank ownership lock: define MEM_ARB_LOCK_EN.
// Ports:
//   clk      system clock, all state on posedge
//   reset_n  asynchronous active-low reset
//   bus      mem_arbiter_if.slave: requester req/we/addr/wdata/lock,
//            gnt/rvalid/rdata, and per-bank read/write address, data, strobe
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRBITS = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus
);

  // Build one requester's view of a given bank; valid only when that
  // requester is asking and its address bit 0 selects the bank.
  function automatic bank_req_t mk_req(input logic req, input logic we,
                                       input logic [ADDRBITS-1:0] addr,
                                       input logic [7:0] wdata,
                                       input logic bank);
    bank_req_t r;
    r                      = '0;
    r.valid                = req & (addr[0] == bank);
    r.we                   = we;
    r.waddr[ADDRBITS-2:0]  = addr[ADDRBITS-1:1];
    r.wdata                = wdata;
    return r;
  endfunction

  bank_req_t  even0, even1, odd0, odd1;
  logic [1:0] gnt_even, gnt_odd;

  assign even0 = mk_req(bus.req0, bus.we0, bus.addr0, bus.wdata0, BANK_EVEN);
  assign even1 = mk_req(bus.req1, bus.we1, bus.addr1, bus.wdata1, BANK_EVEN);
  assign odd0  = mk_req(bus.req0, bus.we0, bus.addr0, bus.wdata0, BANK_ODD);
  assign odd1  = mk_req(bus.req1, bus.we1, bus.addr1, bus.wdata1, BANK_ODD);

  mem_arb_bank #(.ADDRBITS(ADDRBITS)) u_bank_even (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0_i       (even0),
    .req1_i       (even1),
    .lock0_i      (bus.lock0),
    .lock1_i      (bus.lock1),
    .own_req0_i   (bus.req0),
    .own_req1_i   (bus.req1),
    .gnt_o        (gnt_even),
    .read_addr_o  (bus.read_addr_even),
    .write_addr_o (bus.write_addr_even),
    .write_en_o   (bus.write_en_even),
    .write_data_o (bus.write_data_even)
  );

  mem_arb_bank #(.ADDRBITS(ADDRBITS)) u_bank_odd (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0_i       (odd0),
    .req1_i       (odd1),
    .lock0_i      (bus.lock0),
    .lock1_i      (bus.lock1),
    .own_req0_i   (bus.req0),
    .own_req1_i   (bus.req1),
    .gnt_o        (gnt_odd),
    .read_addr_o  (bus.read_addr_odd),
    .write_addr_o (bus.write_addr_odd),
    .write_en_o   (bus.write_en_odd),
    .write_data_o (bus.write_data_odd)
  );

  // Each requester only ever targets one bank, so its grant comes from there.
  assign bus.gnt0 = bus.addr0[0] ? gnt_odd[0] : gnt_even[0];
  assign bus.gnt1 = bus.addr1[0] ? gnt_odd[1] : gnt_even[1];

  // Read return pipeline: remember which bank each granted read went to so
  // the memory's one-cycle-late data is steered back to its requester.
  logic [1:0] rd_pend_q, rd_pend_d;
  logic [1:0] rd_bank_q, rd_bank_d;

  assign rd_pend_d = {bus.req1 & bus.gnt1 & ~bus.we1,
                      bus.req0 & bus.gnt0 & ~bus.we0};
  assign rd_bank_d = {bus.addr1[0], bus.addr0[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= '0;
      rd_bank_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign bus.rvalid0 = rd_pend_q[0];
  assign bus.rvalid1 = rd_pend_q[1];
  assign bus.rdata0  = !rd_pend_q[0] ? 8'h00 :
                       (rd_bank_q[0] ? bus.read_data_odd : bus.read_data_even);
  assign bus.rdata1  = !rd_pend_q[1] ? 8'h00 :
                       (rd_bank_q[1] ? bus.read_data_odd : bus.read_data_even);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of per-cycle vectors with
// hand-computed grants, bank outputs and read returns, followed by directed
// sequences for reset during a read and locked/unlocked contention.
// Compile with +define+MEM_ARB_LOCK_EN to exercise the lock build.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDRBITS(16)) bus ();

  mem_arbiter #(.ADDRBITS(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Byte-bank memory model: synchronous write, one-cycle registered read.
  // Known contents are (re)loaded during reset.
  logic [7:0] mem_even [0:32767];
  logic [7:0] mem_odd  [0:32767];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_even[15'h1000] <= 8'h11;
      mem_even[15'h1001] <= 8'h22;
      mem_even[15'h1002] <= 8'h33;
      mem_even[15'h1003] <= 8'h44;
      mem_even[15'h1004] <= 8'h66;
      mem_odd[15'h1801]  <= 8'h5C;
      bus.read_data_even <= 8'h00;
      bus.read_data_odd  <= 8'h00;
    end else begin
      if (bus.write_en_even) mem_even[bus.write_addr_even] <= bus.write_data_even;
      if (bus.write_en_odd)  mem_odd[bus.write_addr_odd]   <= bus.write_data_odd;
      bus.read_data_even <= mem_even[bus.read_addr_even];
      bus.read_data_odd  <= mem_odd[bus.read_addr_odd];
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [15:0] a0,
                       input logic [7:0] d0, input logic l0,
                       input logic r1, input logic w1, input logic [15:0] a1,
                       input logic [7:0] d1, input logic l1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0; bus.lock0 = l0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.lock1 = l1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        rst;
    logic        r0, w0; logic [15:0] a0; logic [7:0] d0;
    logic        r1, w1; logic [15:0] a1; logic [7:0] d1;
    logic        g0, g1;
    logic        we_e; logic [14:0] ra_e, wa_e; logic [7:0] wd_e;
    logic        we_o; logic [14:0] ra_o, wa_o; logic [7:0] wd_o;
    logic        rv0; logic [7:0] rd0;
    logic        rv1; logic [7:0] rd1;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // rst | req0 we0 addr0 wdata0 | req1 we1 addr1 wdata1 | gnt0 gnt1 |
    // even: we ra wa wd | odd: we ra wa wd | rvalid0 rdata0 rvalid1 rdata1
    // Separate banks in one cycle: CPU reads even, DMA writes odd.
    vecs[0]  = '{1, 1,0,16'h2000,8'h00, 1,1,16'h2001,8'hA5, 1,1,
                 0,15'h1000,15'h0000,8'h00, 1,15'h0000,15'h1000,8'hA5, 0,8'h00, 0,8'h00};
    vecs[1]  = '{0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,
                 0,15'h0000,15'h0000,8'h00, 0,15'h0000,15'h0000,8'h00, 1,8'h11, 0,8'h00};
    // Even-bank contention after reset: grants 0,1,0 then the lone DMA read.
    vecs[2]  = '{1, 1,0,16'h2002,8'h00, 1,0,16'h2004,8'h00, 1,0,
                 0,15'h1001,15'h0000,8'h00, 0,15'h0000,15'h0000,8'h00, 0,8'h00, 0,8'h00};
    vecs[3]  = '{0, 1,0,16'h2006,8'h00, 1,0,16'h2004,8'h00, 0,1,
                 0,15'h1002,15'h0000,8'h00, 0,15'h0000,15'h0000,8'h00, 1,8'h22, 0,8'h00};
    vecs[4]  = '{0, 1,0,16'h2006,8'h00, 1,0,16'h2008,8'h00, 1,0,
                 0,15'h1003,15'h0000,8'h00, 0,15'h0000,15'h0000,8'h00, 0,8'h00, 1,8'h33};
    vecs[5]  = '{0, 0,0,16'h0000,8'h00, 1,0,16'h2008,8'h00, 0,1,
                 0,15'h1004,15'h0000,8'h00, 0,15'h0000,15'h0000,8'h00, 1,8'h44, 0,8'h00};
    // Odd-bank read latency from a preloaded location.
    vecs[6]  = '{0, 0,0,16'h0000,8'h00, 1,0,16'h3003,8'h00, 0,1,
                 0,15'h0000,15'h0000,8'h00, 0,15'h1801,15'h0000,8'h00, 0,8'h00, 1,8'h66};
    vecs[7]  = '{0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,
                 0,15'h0000,15'h0000,8'h00, 0,15'h0000,15'h0000,8'h00, 0,8'h00, 1,8'h5C};
    // Odd-bank write contention (last_odd = 1 so CPU first), then read back.
    vecs[8]  = '{0, 1,1,16'h2003,8'h77, 1,1,16'h2005,8'h88, 1,0,
                 0,15'h0000,15'h0000,8'h00, 1,15'h0000,15'h1001,8'h77, 0,8'h00, 0,8'h00};
    vecs[9]  = '{0, 0,0,16'h0000,8'h00, 1,1,16'h2005,8'h88, 0,1,
                 0,15'h0000,15'h0000,8'h00, 1,15'h0000,15'h1002,8'h88, 0,8'h00, 0,8'h00};
    vecs[10] = '{0, 1,0,16'h2003,8'h00, 0,0,16'h0000,8'h00, 1,0,
                 0,15'h0000,15'h0000,8'h00, 0,15'h1001,15'h0000,8'h00, 0,8'h00, 0,8'h00};
    vecs[11] = '{0, 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,
                 0,15'h0000,15'h0000,8'h00, 0,15'h0000,15'h0000,8'h00, 1,8'h77, 0,8'h00};

    idle();
    #12;
    reset_n = 1'b1;

    // Reset state: nothing granted, nothing returned, bank ports quiet.
    @(negedge clk);
    #1;
    check("reset_gnt_ret", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                            bus.rdata0, bus.rdata1}, 64'h0);
    check("reset_bank", {bus.write_en_even, bus.write_en_odd, bus.read_addr_even,
                         bus.read_addr_odd}, 64'h0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0, 1'b0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, 1'b0);
      #1;
      check($sformatf("v%0d_gnt", i), {bus.gnt0, bus.gnt1}, {vecs[i].g0, vecs[i].g1});
      check($sformatf("v%0d_even", i),
            {bus.write_en_even, bus.read_addr_even, bus.write_addr_even, bus.write_data_even},
            {vecs[i].we_e, vecs[i].ra_e, vecs[i].wa_e, vecs[i].wd_e});
      check($sformatf("v%0d_odd", i),
            {bus.write_en_odd, bus.read_addr_odd, bus.write_addr_odd, bus.write_data_odd},
            {vecs[i].we_o, vecs[i].ra_o, vecs[i].wa_o, vecs[i].wd_o});
      check($sformatf("v%0d_ret", i),
            {bus.rvalid0, bus.rdata0, bus.rvalid1, bus.rdata1},
            {vecs[i].rv0, vecs[i].rd0, vecs[i].rv1, vecs[i].rd1});
    end

    // Reset mid-read: the grant sets last_even to 0, so only a working reset
    // lets requester 0 win the following contention.
    @(negedge clk);
    drive(1, 0, 16'h2000, 8'h0, 0, 0, 0, 16'h0, 8'h0, 0);
    #1;
    check("rst_mid_gnt0", bus.gnt0, 1'b1);
    @(posedge clk);
    #1;
    check("rst_mid_rvalid_pre", bus.rvalid0, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_rvalid_in_reset", {bus.rvalid0, bus.rdata0}, 9'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_rvalid_post", {bus.rvalid0, bus.rvalid1}, 2'b00);
    drive(1, 0, 16'h2000, 8'h0, 0, 1, 0, 16'h2002, 8'h0, 0);
    #1;
    check("rst_mid_contention", {bus.gnt0, bus.gnt1}, 2'b10);
    @(negedge clk);
    idle();

    do_reset();
`ifdef MEM_ARB_LOCK_EN
    // CPU locks the even bank for three writes; DMA is stalled throughout.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 1, 16'h2010 + 16'(2 * k), 8'(8'hB0 + k), (k < 2),
            1, 0, 16'h2020, 8'h0, 0);
      #1;
      check($sformatf("lock_c%0d_gnt", k), {bus.gnt0, bus.gnt1}, 2'b10);
    end
    @(negedge clk);
    drive(0, 0, 16'h0, 8'h0, 0, 1, 0, 16'h2020, 8'h0, 0);
    #1;
    check("lock_release_gnt", {bus.gnt0, bus.gnt1}, 2'b01);
`else
    // Same stimulus shape without locking: pure round-robin alternation.
    begin
      logic [15:0] a0_seq [4];
      logic [15:0] a1_seq [4];
      logic [1:0]  g_seq  [4];
      a0_seq = '{16'h2010, 16'h2012, 16'h2012, 16'h2014};
      a1_seq = '{16'h2020, 16'h2020, 16'h2022, 16'h2022};
      g_seq  = '{2'b10, 2'b01, 2'b10, 2'b01};
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        drive(1, 1, a0_seq[k], 8'(8'hB0 + k), 1, 1, 0, a1_seq[k], 8'h0, 0);
        #1;
        check($sformatf("nolock_c%0d_gnt", k), {bus.gnt0, bus.gnt1}, g_seq[k]);
      end
    end
`endif
    @(negedge clk);
    idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
